// File: rtl/wb_master_pipelined.sv
// wb_master_pipelined: Wishbone B4 pipelined master with bounded outstanding requests and in-order responses
module wb_master_pipelined #(
  parameter int adr_width       = 16,
  parameter int dat_width       = 16,
  parameter int max_outstanding = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_we,
  input  logic [adr_width-1:0] cmd_adr,
  input  logic [dat_width-1:0] cmd_dat,
  input  logic                 cmd_last,
  output logic                 rsp_valid,
  output logic [dat_width-1:0] rsp_dat,
  output logic                 rsp_err,
  output logic                 spurious_ack,
  output logic [adr_width-1:0] wb_adr_o,
  output logic [dat_width-1:0] wb_dat_o,
  output logic                 wb_we_o,
  output logic                 wb_cyc_o,
  output logic                 wb_stb_o,
  input  logic [dat_width-1:0] wb_dat_i,
  input  logic                 wb_ack_i,
  input  logic                 wb_err_i,
  input  logic                 wb_stall_i
);
  typedef enum logic [1:0] {IDLE, BUS, DRAIN} state_t;
  state_t state;
  logic [3:0] cnt, cnt_n;
  logic [max_outstanding-1:0] weq, weq_n;
  logic rdy_en, issue, hit, ack_ok, accept;
  assign issue  = wb_stb_o & ~wb_stall_i;
  assign hit    = wb_ack_i | wb_err_i;
  assign ack_ok = hit & (cnt != 4'd0);
  assign cnt_n  = cnt + {3'd0, issue} - {3'd0, ack_ok};
  assign cmd_ready = rdy_en & (state != DRAIN) & (~wb_stb_o | ~wb_stall_i) &
                     (({1'b0, cnt} + {4'd0, issue}) < 5'(max_outstanding));
  assign accept = cmd_valid & cmd_ready;
  // we-bit queue with the oldest request at bit 0; the new entry lands after the survivors
  always_comb begin
    weq_n = ack_ok ? weq >> 1 : weq;
    for (int i = 0; i < max_outstanding; i++)
      if (issue && 4'(i) == cnt - {3'd0, ack_ok}) weq_n[i] = wb_we_o;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      weq          <= '0;
      rdy_en       <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_dat      <= '0;
      rsp_err      <= 1'b0;
      spurious_ack <= 1'b0;
      wb_adr_o     <= '0;
      wb_dat_o     <= '0;
      wb_we_o      <= 1'b0;
      wb_cyc_o     <= 1'b0;
      wb_stb_o     <= 1'b0;
    end else begin
      rdy_en       <= 1'b1;
      cnt          <= cnt_n;
      weq          <= weq_n;
      rsp_valid    <= ack_ok;
      rsp_err      <= ack_ok & wb_err_i;
      rsp_dat      <= (ack_ok & ~weq[0]) ? wb_dat_i : '0;
      spurious_ack <= spurious_ack | (hit & (cnt == 4'd0));
      if (accept) begin
        wb_cyc_o <= 1'b1;
        wb_stb_o <= 1'b1;
        wb_adr_o <= cmd_adr;
        wb_we_o  <= cmd_we;
        wb_dat_o <= cmd_we ? cmd_dat : '0;
        state    <= cmd_last ? DRAIN : BUS;
      end else if (issue) wb_stb_o <= 1'b0;
      if (state == DRAIN && !wb_stb_o && cnt_n == 4'd0) begin
        wb_cyc_o <= 1'b0;
        state    <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_wb_master_pipelined.sv
// tb_wb_master_pipelined: directed scenarios against a queue-based pipelined Wishbone slave model
module tb_wb_master_pipelined;
  logic clk = 0, rst_n = 1;
  always #5 clk = ~clk;
  logic cmd_valid = 0, cmd_we = 0, cmd_last = 0;
  logic [15:0] cmd_adr = 0, cmd_dat = 0;
  logic cmd_ready, rsp_valid, rsp_err, spurious_ack;
  logic [15:0] rsp_dat, wb_adr_o, wb_dat_o;
  logic [15:0] wb_dat_i = 0;
  logic wb_we_o, wb_cyc_o, wb_stb_o;
  logic wb_ack_i = 0, wb_err_i = 0, wb_stall_i = 0;
  int errors = 0, checks = 0, tmo = 0;

  wb_master_pipelined #(.adr_width(16), .dat_width(16), .max_outstanding(4)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_we(cmd_we), .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_last(cmd_last),
    .rsp_valid(rsp_valid), .rsp_dat(rsp_dat), .rsp_err(rsp_err), .spurious_ack(spurious_ack),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o),
    .wb_stb_o(wb_stb_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
    .wb_stall_i(wb_stall_i)
  );

  typedef struct packed {logic [15:0] adr; logic we; int t;} req_t;
  req_t q[$];
  int cyc_cnt = 0, ack_wait = 0, err_at = -1, resp_idx = 0, maxq = 0, n_iss = 0;
  int first_iss = -1, last_iss = 0, last_ack = 0, fall_cyc = -1, n_falls = 0;
  int hold_viol = 0, stall_hits = 0, stb_cycles = 0;
  bit hold_ack = 0, stall_mode = 0, force_ack = 0, stalled_prev = 0, prev_cyc = 0;
  logic [15:0] held_adr = 0;
  logic [15:0] iss_adr[$], iss_dat[$], r_dat[$];
  logic iss_we[$], r_err[$];

  // slave: retire on ack/err edges, accept on stb & !stall edges
  always @(posedge clk) begin
    cyc_cnt++;
    if (!rst_n) begin
      q.delete();
      stalled_prev = 0;
    end else begin
      if ((wb_ack_i || wb_err_i) && q.size() > 0) begin
        void'(q.pop_front());
        resp_idx++;
        last_ack = cyc_cnt;
      end
      if (stalled_prev && (!wb_stb_o || wb_adr_o !== held_adr)) hold_viol++;
      if (wb_stb_o && wb_stall_i) stall_hits++;
      if (wb_stb_o) stb_cycles++;
      stalled_prev = wb_stb_o && wb_stall_i;
      held_adr = wb_adr_o;
      if (wb_stb_o && !wb_stall_i) begin
        q.push_back('{adr: wb_adr_o, we: wb_we_o, t: cyc_cnt});
        iss_adr.push_back(wb_adr_o);
        iss_dat.push_back(wb_dat_o);
        iss_we.push_back(wb_we_o);
        n_iss++;
        if (first_iss < 0) first_iss = cyc_cnt;
        last_iss = cyc_cnt;
      end
      if (q.size() > maxq) maxq = q.size();
    end
  end

  always @(negedge clk) begin
    wb_stall_i = stall_mode ? ~wb_stall_i : 1'b0;
    if (q.size() > 0 && !hold_ack && cyc_cnt - q[0].t >= ack_wait) begin
      wb_ack_i = (resp_idx != err_at);
      wb_err_i = (resp_idx == err_at);
      wb_dat_i = q[0].we ? 16'hdead : q[0].adr + 16'd200;
    end else begin
      wb_ack_i = force_ack;
      wb_err_i = 0;
      wb_dat_i = 0;
    end
  end

  always @(negedge clk) begin
    if (rsp_valid) begin
      r_dat.push_back(rsp_dat);
      r_err.push_back(rsp_err);
    end
    if (prev_cyc && !wb_cyc_o) begin
      fall_cyc = cyc_cnt;
      n_falls++;
    end
    prev_cyc = wb_cyc_o;
  end

  task automatic clear_logs();
    iss_adr.delete(); iss_dat.delete(); iss_we.delete(); r_dat.delete(); r_err.delete();
    n_iss = 0; first_iss = -1; maxq = 0; fall_cyc = -1; n_falls = 0; hold_viol = 0;
    stall_hits = 0; stb_cycles = 0; resp_idx = 0; tmo = 0;
  endtask

  task automatic send(input logic we, input logic [15:0] adr, input logic [15:0] dat, input logic last);
    int n = 0;
    @(negedge clk);
    cmd_valid = 1; cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_last = last;
    #1;
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 200) tmo++;
    @(posedge clk);
  endtask

  task automatic finish_cmds();
    int n = 0;
    @(negedge clk);
    cmd_valid = 0; cmd_last = 0;
    while (wb_cyc_o && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) tmo++;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    #1 rst_n = 0;
    #1;
    checks++; if (wb_cyc_o !== 1'b0) begin errors++; $display("FAIL reset_cyc: got %b want 0", wb_cyc_o); end
    checks++; if (wb_stb_o !== 1'b0) begin errors++; $display("FAIL reset_stb: got %b want 0", wb_stb_o); end
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", cmd_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    checks++; if (spurious_ack !== 1'b0) begin errors++; $display("FAIL reset_spurious: got %b want 0", spurious_ack); end
    checks++; if ({wb_adr_o, wb_dat_o, wb_we_o} !== 33'd0) begin errors++; $display("FAIL reset_bus: got %h want 0", {wb_adr_o, wb_dat_o, wb_we_o}); end
    repeat (2) @(negedge clk);
    rst_n = 1;
    #1;
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL ready_before_clk: got %b want 0", cmd_ready); end
    @(posedge clk); #1;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL ready_after_clk: got %b want 1", cmd_ready); end
  endtask

  task automatic test_single_write();
    clear_logs();
    send(1, 16'd1, 16'd101, 1);
    finish_cmds();
    checks++; if (tmo !== 0) begin errors++; $display("FAIL single_timeout: got %0d want 0", tmo); end
    checks++; if (stb_cycles !== 1) begin errors++; $display("FAIL single_stb_cycles: got %0d want 1", stb_cycles); end
    checks++; if (iss_adr.size() !== 1 || iss_adr[0] !== 16'd1 || iss_dat[0] !== 16'd101 || iss_we[0] !== 1'b1)
      begin errors++; $display("FAIL single_bus: got n=%0d adr=%0d dat=%0d want n=1 adr=1 dat=101", iss_adr.size(), iss_adr[0], iss_dat[0]); end
    checks++; if (r_dat.size() !== 1 || r_dat[0] !== 16'd0 || r_err[0] !== 1'b0)
      begin errors++; $display("FAIL single_rsp: got n=%0d dat=%0d want n=1 dat=0", r_dat.size(), r_dat[0]); end
    checks++; if (fall_cyc !== last_ack) begin errors++; $display("FAIL single_cyc_drop: got %0d want %0d", fall_cyc, last_ack); end
  endtask

  task automatic test_back_to_back();
    clear_logs();
    for (int i = 0; i < 10; i++) send(1, 16'(11 + i), 16'(211 + i), i == 9);
    finish_cmds();
    checks++; if (tmo !== 0) begin errors++; $display("FAIL b2b_timeout: got %0d want 0", tmo); end
    checks++; if (n_iss !== 10 || stb_cycles !== 10) begin errors++; $display("FAIL b2b_issues: got %0d/%0d want 10/10", n_iss, stb_cycles); end
    checks++; if (last_iss - first_iss !== 9) begin errors++; $display("FAIL b2b_consecutive: got %0d want 9", last_iss - first_iss); end
    checks++; if (n_falls !== 1) begin errors++; $display("FAIL b2b_cyc_held: got %0d want 1", n_falls); end
    checks++; if (r_dat.size() !== 10) begin errors++; $display("FAIL b2b_rsp_count: got %0d want 10", r_dat.size()); end
    for (int i = 0; i < 10 && i < iss_adr.size() && i < r_dat.size(); i++) begin
      checks++;
      if (iss_adr[i] !== 16'(11 + i) || iss_dat[i] !== 16'(211 + i) || r_dat[i] !== 16'd0)
        begin errors++; $display("FAIL b2b_item%0d: got adr=%0d dat=%0d rsp=%0d want %0d %0d 0", i, iss_adr[i], iss_dat[i], r_dat[i], 11 + i, 211 + i); end
    end
  endtask

  task automatic test_stall_reads();
    clear_logs();
    stall_mode = 1;
    for (int i = 0; i < 10; i++) send(0, 16'(11 + i), 16'hffff, i == 9);
    finish_cmds();
    stall_mode = 0;
    checks++; if (tmo !== 0) begin errors++; $display("FAIL stall_timeout: got %0d want 0", tmo); end
    checks++; if (stall_hits == 0 || hold_viol !== 0) begin errors++; $display("FAIL stall_hold: got stalls=%0d viol=%0d want stalls>0 viol=0", stall_hits, hold_viol); end
    checks++; if (maxq > 4) begin errors++; $display("FAIL stall_outstanding: got %0d want <=4", maxq); end
    checks++; if (r_dat.size() !== 10) begin errors++; $display("FAIL stall_rsp_count: got %0d want 10", r_dat.size()); end
    for (int i = 0; i < 10 && i < r_dat.size() && i < iss_dat.size(); i++) begin
      checks++;
      if (r_dat[i] !== 16'(211 + i) || iss_dat[i] !== 16'd0 || iss_we[i] !== 1'b0)
        begin errors++; $display("FAIL stall_item%0d: got rsp=%0d wdat=%0d want %0d 0", i, r_dat[i], iss_dat[i], 211 + i); end
    end
  endtask

  task automatic test_outstanding_limit();
    int low = 0;
    clear_logs();
    hold_ack = 1;
    for (int i = 0; i < 4; i++) send(0, 16'(11 + i), 16'd0, 0);
    @(negedge clk);
    cmd_valid = 0;
    repeat (6) begin
      @(negedge clk); #1;
      if (!cmd_ready) low++;
    end
    checks++; if (n_iss !== 4) begin errors++; $display("FAIL limit_issues: got %0d want 4", n_iss); end
    checks++; if (low !== 6) begin errors++; $display("FAIL limit_ready_low: got %0d want 6", low); end
    @(posedge clk); #1;
    hold_ack = 0;
    send(0, 16'd15, 16'd0, 1);
    finish_cmds();
    checks++; if (tmo !== 0) begin errors++; $display("FAIL limit_timeout: got %0d want 0", tmo); end
    checks++; if (maxq !== 4) begin errors++; $display("FAIL limit_max: got %0d want 4", maxq); end
    checks++; if (fall_cyc !== last_ack) begin errors++; $display("FAIL limit_cyc_drop: got %0d want %0d", fall_cyc, last_ack); end
    checks++; if (r_dat.size() !== 5) begin errors++; $display("FAIL limit_rsp_count: got %0d want 5", r_dat.size()); end
    for (int i = 0; i < 5 && i < r_dat.size(); i++) begin
      checks++;
      if (r_dat[i] !== 16'(211 + i)) begin errors++; $display("FAIL limit_item%0d: got %0d want %0d", i, r_dat[i], 211 + i); end
    end
  endtask

  task automatic test_err();
    clear_logs();
    err_at = 2;
    for (int i = 0; i < 5; i++) send(0, 16'(11 + i), 16'd0, i == 4);
    finish_cmds();
    err_at = -1;
    checks++; if (tmo !== 0) begin errors++; $display("FAIL err_timeout: got %0d want 0", tmo); end
    checks++; if (r_dat.size() !== 5) begin errors++; $display("FAIL err_rsp_count: got %0d want 5", r_dat.size()); end
    for (int i = 0; i < 5 && i < r_dat.size(); i++) begin
      checks++;
      if (r_err[i] !== (i == 2) || (i != 2 && r_dat[i] !== 16'(211 + i)))
        begin errors++; $display("FAIL err_item%0d: got err=%b dat=%0d want err=%b dat=%0d", i, r_err[i], r_dat[i], i == 2, 211 + i); end
    end
  endtask

  task automatic test_reset_mid();
    clear_logs();
    hold_ack = 1;
    for (int i = 0; i < 3; i++) send(0, 16'(31 + i), 16'd0, 0);
    @(negedge clk);
    cmd_valid = 0;
    repeat (2) @(negedge clk);
    checks++; if (n_iss !== 3) begin errors++; $display("FAIL mid_issues: got %0d want 3", n_iss); end
    #2 rst_n = 0;
    #1;
    checks++; if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0 || cmd_ready !== 1'b0)
      begin errors++; $display("FAIL mid_reset_bus: got cyc=%b stb=%b rdy=%b want 0 0 0", wb_cyc_o, wb_stb_o, cmd_ready); end
    hold_ack = 0;
    repeat (3) @(negedge clk);
    rst_n = 1;
    repeat (4) @(negedge clk);
    checks++; if (r_dat.size() !== 0) begin errors++; $display("FAIL mid_no_rsp: got %0d want 0", r_dat.size()); end
    checks++; if (cmd_ready !== 1'b1 || spurious_ack !== 1'b0) begin errors++; $display("FAIL mid_after: got rdy=%b sp=%b want 1 0", cmd_ready, spurious_ack); end
    @(posedge clk); #1;
    force_ack = 1;
    @(posedge clk); @(posedge clk); #1;
    force_ack = 0;
    repeat (3) @(negedge clk);
    checks++; if (spurious_ack !== 1'b1) begin errors++; $display("FAIL spurious_set: got %b want 1", spurious_ack); end
    checks++; if (r_dat.size() !== 0 || wb_cyc_o !== 1'b0) begin errors++; $display("FAIL spurious_no_rsp: got n=%0d cyc=%b want 0 0", r_dat.size(), wb_cyc_o); end
    send(1, 16'd40, 16'd7, 1);
    finish_cmds();
    checks++; if (r_dat.size() !== 1 || spurious_ack !== 1'b1) begin errors++; $display("FAIL spurious_sticky: got n=%0d sp=%b want 1 1", r_dat.size(), spurious_ack); end
    #2 rst_n = 0;
    #1;
    checks++; if (spurious_ack !== 1'b0) begin errors++; $display("FAIL spurious_clear: got %b want 0", spurious_ack); end
    @(negedge clk);
    rst_n = 1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_back_to_back();
    test_stall_reads();
    test_outstanding_limit();
    test_err();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end
endmodule
